// File: rtl/float_sched_pkg.sv
// Shared widths, output field offsets and sizing helpers for the float_to_float_signed scheduler.
package float_sched_pkg;

    localparam int DEF_SIGNED_EXP  = 3;
    localparam int DEF_SIGNED_FRAC = 8;

    // out_data layout, LSB first: frac, exp, isZero, isInf, sign.
    localparam int OUT_FRAC_LSB = 0;

    function automatic int outExpLsb(input int signedFrac);
        return OUT_FRAC_LSB + signedFrac;
    endfunction

    function automatic int outZeroBit(input int signedExp, input int signedFrac);
        return outExpLsb(signedFrac) + signedExp;
    endfunction

    function automatic int outInfBit(input int signedExp, input int signedFrac);
        return outZeroBit(signedExp, signedFrac) + 1;
    endfunction

    function automatic int outSignBit(input int signedExp, input int signedFrac);
        return outZeroBit(signedExp, signedFrac) + 2;
    endfunction

    function automatic int signedFloatWidth(input int signedExp, input int signedFrac);
        return 3 + signedExp + signedFrac;
    endfunction

    function automatic int idWidth(input int numReq);
        return (numReq <= 2) ? 1 : $clog2(numReq);
    endfunction

endpackage

// File: rtl/float_to_float_signed.sv
// Combinational IEEE-style float to small signed-exponent float converter (round to nearest even).
module float_to_float_signed
    import float_sched_pkg::*;
#(
    parameter int EXP          = 8,
    parameter int FRAC         = 23,
    parameter int SIGNED_EXP   = DEF_SIGNED_EXP,
    parameter int SIGNED_FRAC  = DEF_SIGNED_FRAC,
    parameter int SATURATE_MAX = 1,
    parameter int DENORMALS    = 0
) (
    input  logic [EXP+FRAC:0]                                     floatIn,
    output logic [signedFloatWidth(SIGNED_EXP, SIGNED_FRAC)-1:0]  signedOut
);
    localparam int IW       = (((EXP + DENORMALS) > SIGNED_EXP) ? (EXP + DENORMALS) : SIGNED_EXP) + 1;
    localparam int BIAS     = (1 << (EXP - 1)) - 1;
    localparam int MAX_E    = (1 << (SIGNED_EXP - 1)) - 1;
    localparam int MIN_E    = -(1 << (SIGNED_EXP - 1));
    localparam int EW       = FRAC + SIGNED_FRAC + 1;
    localparam int EXP_LSB  = outExpLsb(SIGNED_FRAC);
    localparam int ZERO_BIT = outZeroBit(SIGNED_EXP, SIGNED_FRAC);
    localparam int INF_BIT  = outInfBit(SIGNED_EXP, SIGNED_FRAC);
    localparam int SIGN_BIT = outSignBit(SIGNED_EXP, SIGNED_FRAC);

    logic                    sign;
    logic [EXP-1:0]          expIn;
    logic [FRAC-1:0]         fracIn;
    logic [FRAC-1:0]         mant;
    logic signed [IW-1:0]    eUnb;
    logic signed [IW-1:0]    eRound;
    logic [EW-1:0]           ext;
    logic [SIGNED_FRAC-1:0]  kept;
    logic                    guardBit;
    logic                    stickyBit;
    logic                    roundUp;
    logic [SIGNED_FRAC:0]    rounded;
    logic                    isInf;
    logic                    isZero;
    logic [SIGNED_EXP-1:0]   expOut;
    logic [SIGNED_FRAC-1:0]  fracOut;
    int                      lead;

    always_comb begin
        sign   = floatIn[EXP+FRAC];
        expIn  = floatIn[FRAC +: EXP];
        fracIn = floatIn[FRAC-1:0];
        mant   = fracIn;
        eUnb   = IW'(expIn) - IW'(BIAS);
        lead   = 0;
        for (int i = 0; i < FRAC; i++) begin
            if (fracIn[i]) begin
                lead = i;
            end
        end
        // Renormalise a denormal: shift the leading one out of the fraction field.
        if ((DENORMALS != 0) && (expIn == '0) && (fracIn != '0)) begin
            mant = fracIn << (FRAC - lead);
            eUnb = IW'(1 - BIAS - (FRAC - lead));
        end

        ext       = {mant, {(SIGNED_FRAC + 1){1'b0}}};
        kept      = ext[EW-1 -: SIGNED_FRAC];
        guardBit  = ext[FRAC];
        stickyBit = |ext[FRAC-1:0];
        roundUp   = guardBit & (stickyBit | kept[0]);
        rounded   = {1'b0, kept} + (SIGNED_FRAC + 1)'(roundUp);
        eRound    = eUnb + IW'(rounded[SIGNED_FRAC]);

        isInf   = 1'b0;
        isZero  = 1'b0;
        expOut  = '0;
        fracOut = '0;
        if (expIn == '1) begin
            isInf = 1'b1;
        end else if ((expIn == '0) && ((DENORMALS == 0) || (fracIn == '0))) begin
            isZero = 1'b1;
        end else if (eRound > MAX_E) begin
            if (SATURATE_MAX != 0) begin
                expOut  = SIGNED_EXP'(MAX_E);
                fracOut = '1;
            end else begin
                isInf = 1'b1;
            end
        end else if (eRound < MIN_E) begin
            isZero = 1'b1;
        end else begin
            expOut  = eRound[SIGNED_EXP-1:0];
            fracOut = rounded[SIGNED_FRAC-1:0];
        end

        signedOut                                = '0;
        signedOut[SIGN_BIT]                      = sign;
        signedOut[INF_BIT]                       = isInf;
        signedOut[ZERO_BIT]                      = isZero;
        signedOut[EXP_LSB +: SIGNED_EXP]         = expOut;
        signedOut[OUT_FRAC_LSB +: SIGNED_FRAC]   = fracOut;
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Rotating-priority arbiter: searches req from ptr upward (mod N) and grants the first hit.
module round_robin_arbiter
    import float_sched_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]            req,
    input  logic                    enable,
    input  logic [idWidth(N)-1:0]   ptr,
    output logic [N-1:0]            grant,
    output logic [idWidth(N)-1:0]   grant_id
);
    localparam int IW = idWidth(N);

    int   idx;
    logic found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        found    = 1'b0;
        idx      = 0;
        for (int i = 0; i < N; i++) begin
            // Explicit wrap so non power-of-two N never indexes past the last requester.
            idx = int'(ptr) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (enable && !found && req[idx]) begin
                grant[idx] = 1'b1;
                grant_id   = IW'(idx);
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/float_to_float_signed_scheduler.sv
// Round-robin scheduler sharing one float_to_float_signed converter between NUM_REQ requesters.
// Optional statistics counters are built when FLOAT_SCHED_STATS_EN is defined.
module float_to_float_signed_scheduler
    import float_sched_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int EXP          = 8,
    parameter int FRAC         = 23,
    parameter int SIGNED_EXP   = DEF_SIGNED_EXP,
    parameter int SIGNED_FRAC  = DEF_SIGNED_FRAC,
    parameter int SATURATE_MAX = 1,
    parameter int DENORMALS    = 0
) (
    input  logic                                                 clock,
    input  logic                                                 resetn,
    input  logic [NUM_REQ-1:0]                                   in_valid,
    output logic [NUM_REQ-1:0]                                   in_ready,
    input  logic [NUM_REQ*(1+EXP+FRAC)-1:0]                      in_data,
    output logic                                                 out_valid,
    input  logic                                                 out_ready,
    output logic [idWidth(NUM_REQ)-1:0]                          out_id,
    output logic [signedFloatWidth(SIGNED_EXP, SIGNED_FRAC)-1:0] out_data
`ifdef FLOAT_SCHED_STATS_EN
    ,
    input  logic                                                 stat_clear,
    output logic [15:0]                                          stat_inf_count,
    output logic [15:0]                                          stat_zero_count
`endif
);
    localparam int FW    = 1 + EXP + FRAC;
    localparam int ID_W  = idWidth(NUM_REQ);
    localparam int OW    = signedFloatWidth(SIGNED_EXP, SIGNED_FRAC);

    // Handshakes: a transfer happens on a rising edge where valid and ready are both 1.
    // Valid never waits for ready; payload is held stable while valid is high and ready low.

    logic               s1Adv;
    logic               s2Adv;
    logic               accept;
    logic [NUM_REQ-1:0] grant;
    logic [ID_W-1:0]    grantId;
    logic [ID_W-1:0]    ptr;
    logic               s1Valid;
    logic [FW-1:0]      s1Float;
    logic [ID_W-1:0]    s1Id;
    logic [OW-1:0]      convOut;
    logic               s2Valid;
    logic [OW-1:0]      s2Data;
    logic [ID_W-1:0]    s2Id;

    assign s2Adv  = !s2Valid || out_ready;
    assign s1Adv  = !s1Valid || s2Adv;
    assign accept = |grant;

    round_robin_arbiter #(
        .N(NUM_REQ)
    ) arbiter (
        .req      (in_valid),
        .enable   (s1Adv),
        .ptr      (ptr),
        .grant    (grant),
        .grant_id (grantId)
    );

    // Held in reset, nothing may be offered to the requesters.
    assign in_ready = grant & {NUM_REQ{resetn}};

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ptr     <= '0;
            s1Valid <= 1'b0;
            s2Valid <= 1'b0;
        end else begin
            if (accept) begin
                ptr <= (grantId == ID_W'(NUM_REQ - 1)) ? '0 : grantId + 1'b1;
            end
            if (s1Adv) begin
                s1Valid <= accept;
            end
            if (s2Adv) begin
                s2Valid <= s1Valid;
            end
        end
    end

    // Payload registers carry no reset; their valid bits qualify them.
    always_ff @(posedge clock) begin
        if (s1Adv) begin
            s1Float <= in_data[int'(grantId)*FW +: FW];
            s1Id    <= grantId;
        end
        if (s2Adv) begin
            s2Data <= convOut;
            s2Id   <= s1Id;
        end
    end

    float_to_float_signed #(
        .EXP          (EXP),
        .FRAC         (FRAC),
        .SIGNED_EXP   (SIGNED_EXP),
        .SIGNED_FRAC  (SIGNED_FRAC),
        .SATURATE_MAX (SATURATE_MAX),
        .DENORMALS    (DENORMALS)
    ) converter (
        .floatIn   (s1Float),
        .signedOut (convOut)
    );

    assign out_valid = s2Valid;
    assign out_id    = s2Id;
    assign out_data  = s2Data;

`ifdef FLOAT_SCHED_STATS_EN
    localparam int INF_BIT  = outInfBit(SIGNED_EXP, SIGNED_FRAC);
    localparam int ZERO_BIT = outZeroBit(SIGNED_EXP, SIGNED_FRAC);

    logic outFire;
    assign outFire = s2Valid && out_ready;

    // Clear has priority over a same-cycle count; both counters stick at all ones.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            stat_inf_count  <= '0;
            stat_zero_count <= '0;
        end else if (stat_clear) begin
            stat_inf_count  <= '0;
            stat_zero_count <= '0;
        end else if (outFire) begin
            if (s2Data[INF_BIT] && (stat_inf_count != 16'hFFFF)) begin
                stat_inf_count <= stat_inf_count + 16'd1;
            end
            if (s2Data[ZERO_BIT] && (stat_zero_count != 16'hFFFF)) begin
                stat_zero_count <= stat_zero_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_float_to_float_signed_scheduler.sv
// Scoreboard bench for float_to_float_signed_scheduler with an arithmetic reference converter.
`timescale 1ns/1ps
module tb_float_to_float_signed_scheduler;
    localparam int NUM_REQ = 4;
    localparam int FW      = 32;
    localparam int OW      = 14;
    localparam int IDW     = 2;
    localparam int SAT_MAX = 1;

    logic                  clock = 1'b0;
    logic                  resetn;
    logic [NUM_REQ-1:0]    in_valid;
    logic [NUM_REQ-1:0]    in_ready;
    logic [NUM_REQ*FW-1:0] in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [IDW-1:0]        out_id;
    logic [OW-1:0]         out_data;
`ifdef FLOAT_SCHED_STATS_EN
    logic                  stat_clear;
    logic [15:0]           stat_inf_count;
    logic [15:0]           stat_zero_count;
`endif

    float_to_float_signed_scheduler #(
        .NUM_REQ(NUM_REQ), .EXP(8), .FRAC(23), .SIGNED_EXP(3), .SIGNED_FRAC(8),
        .SATURATE_MAX(SAT_MAX), .DENORMALS(0)
    ) dut (
        .clock     (clock),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_id    (out_id),
        .out_data  (out_data)
`ifdef FLOAT_SCHED_STATS_EN
        ,
        .stat_clear      (stat_clear),
        .stat_inf_count  (stat_inf_count),
        .stat_zero_count (stat_zero_count)
`endif
    );

    // ---------------- clock / reset ----------------
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [IDW+OW-1:0] exp_q[$];
    int                accLog[$];
    int                outLog[$];
    int                outCyc[$];
    int                checks = 0;
    int                fails  = 0;
    int                mPtr   = 0;
    int                mj;
    int                inflight;
    logic [NUM_REQ-1:0] expGrant;
    logic              prevStall = 1'b0;
    logic [IDW+OW-1:0] prevWord;
    logic [IDW+OW-1:0] popped;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: value = 1.f * 2^u, rounded to 9 significant bits (nearest, ties to even).
    function automatic logic [OW-1:0] refConvert(input logic [31:0] f);
        int      e;
        int      u;
        longint  m;
        longint  q;
        longint  rem;
        logic    s;
        logic [2:0] eb;
        logic [7:0] fb;
        s = f[31];
        e = int'(f[30:23]);
        if (e == 255) return {s, 1'b1, 1'b0, 11'd0};
        if (e == 0)   return {s, 1'b0, 1'b1, 11'd0};
        m   = longint'({1'b1, f[22:0]});
        u   = e - 127;
        q   = m / 32768;
        rem = m % 32768;
        if ((rem > 16384) || ((rem == 16384) && ((q % 2) == 1))) q = q + 1;
        if (q == 512) begin
            q = 256;
            u = u + 1;
        end
        if (u > 3) begin
            if (SAT_MAX != 0) return {s, 2'b00, 3'd3, 8'hFF};
            return {s, 1'b1, 1'b0, 11'd0};
        end
        if (u < -4) return {s, 1'b0, 1'b1, 11'd0};
        eb = u[2:0];
        fb = q[7:0];
        return {s, 2'b00, eb, fb};
    endfunction

    function automatic logic [31:0] randFloat();
        logic [31:0] f;
        int          kind;
        f    = $urandom();
        kind = $urandom_range(0, 9);
        if (kind <= 5)      f[30:23] = 8'($urandom_range(119, 133));
        else if (kind == 6) begin
            f[30:23] = 8'($urandom_range(119, 133));
            f[14:0]  = 15'h4000;
        end else if (kind == 7) begin
            f[30:23] = 8'($urandom_range(119, 133));
            f[22:0]  = 23'h7FFFFF;
        end else if (kind == 8) f[30:23] = 8'hFF;
        else                    f[30:23] = 8'h00;
        return f;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (!resetn) begin
            exp_q.delete();
            mPtr      = 0;
            prevStall = 1'b0;
        end else begin
            inflight = exp_q.size();
            expGrant = '0;
            if ((|in_valid) && ((inflight < 2) || out_ready)) begin
                for (int k = 0; k < NUM_REQ; k++) begin
                    mj = (mPtr + k) % NUM_REQ;
                    if ((expGrant == '0) && in_valid[mj]) expGrant[mj] = 1'b1;
                end
            end
            check("in_ready", 32'(in_ready), 32'(expGrant));
            if (prevStall) begin
                check("stall_valid", 32'(out_valid), 32'd1);
                check("stall_hold", 32'({out_id, out_data}), 32'(prevWord));
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_out: got id %0d data %0h expected no output", out_id, out_data);
                end else begin
                    popped = exp_q.pop_front();
                    if ({out_id, out_data} !== popped) begin
                        fails++;
                        $display("FAIL out_word: got %0h expected %0h (t=%0t)", {out_id, out_data}, popped, $time);
                    end
                    outLog.push_back(int'(out_id));
                    outCyc.push_back(cyc);
                end
            end
            prevStall = out_valid && !out_ready;
            prevWord  = {out_id, out_data};
            for (int k = 0; k < NUM_REQ; k++) begin
                if (in_valid[k] && in_ready[k]) begin
                    exp_q.push_back({IDW'(k), refConvert(in_data[k*FW +: FW])});
                    accLog.push_back(k);
                    mPtr = (k + 1) % NUM_REQ;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input int i, input logic v, input logic [31:0] f);
        in_valid[i]         = v;
        in_data[i*FW +: FW] = f;
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        for (int n = 0; n < 50; n++) begin
            if (exp_q.size() == 0 && !out_valid) break;
            tick();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic sendCheck(input string name, input int i, input logic [31:0] f, input logic [OW-1:0] want);
        setReq(i, 1'b1, f);
        tick();
        in_valid[i] = 1'b0;
        check({name, "_lat1"}, 32'(out_valid), 32'd0);
        tick();
        check({name, "_lat2"}, 32'(out_valid), 32'd1);
        check({name, "_id"}, 32'(out_id), 32'(i));
        check({name, "_data"}, 32'(out_data), 32'(want));
        tick();
    endtask

    task automatic randomCycles(input int n, input int readyPct);
        logic [NUM_REQ-1:0] acc;
        for (int c = 0; c < n; c++) begin
            @(negedge clock);
            acc = in_valid & in_ready;
            @(posedge clock);
            #1;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (acc[i] || !in_valid[i]) setReq(i, $urandom_range(0, 3) != 0, randFloat());
            end
            out_ready = $urandom_range(0, 99) < readyPct;
        end
    endtask

    // ---------------- stimulus ----------------
    logic [31:0]   dirF[13] = '{32'h3F800000, 32'h3FFFFFFF, 32'h42000000, 32'h417FFFFF, 32'h41000000,
                                32'h7F800000, 32'h7FC00000, 32'h00000001, 32'h3C000000, 32'h3F804000,
                                32'h3F80C000, 32'hBD800000, 32'h40200000};
    logic [OW-1:0] dirE[13] = '{14'h0000, 14'h0100, 14'h03FF, 14'h03FF, 14'h0300,
                                14'h1000, 14'h1000, 14'h0800, 14'h0800, 14'h0000,
                                14'h0002, 14'h2400, 14'h0140};
    int a0;

    initial begin
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b1;
        resetn    = 1'b0;
`ifdef FLOAT_SCHED_STATS_EN
        stat_clear = 1'b0;
`endif
        #2;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        in_valid = '1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        in_valid = '0;
`ifdef FLOAT_SCHED_STATS_EN
        check("rst_stat_inf", 32'(stat_inf_count), 32'd0);
        check("rst_stat_zero", 32'(stat_zero_count), 32'd0);
`endif
        repeat (3) @(posedge clock);
        #1;
        resetn = 1'b1;
        tick();

        for (int d = 0; d < 13; d++) sendCheck($sformatf("dir%0d", d), d % NUM_REQ, dirF[d], dirE[d]);
        drain();

        // Backpressure from an empty pipeline: only two requests fit.
        a0        = accLog.size();
        out_ready = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) setReq(i, 1'b1, randFloat());
        repeat (5) tick();
        check("bp_accepts", 32'(accLog.size() - a0), 32'd2);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        repeat (4) tick();
        drain();

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid  = '1;
        tick();
        tick();
        #3;
        resetn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        tick();
        tick();
        out_ready = 1'b1;
        resetn    = 1'b1;
        #1;
        check("post_rst_grant", 32'(in_ready), 32'd1);
        accLog.delete();
        outLog.delete();
        outCyc.delete();

        // Fairness: all requesters hold valid for eight cycles.
        repeat (8) tick();
        in_valid = '0;
        drain();
        check("fair_acc_count", 32'(accLog.size()), 32'd8);
        check("fair_out_count", 32'(outLog.size()), 32'd8);
        for (int k = 0; k < 8; k++) begin
            if (k < accLog.size()) check($sformatf("fair_acc%0d", k), 32'(accLog[k]), 32'(k % NUM_REQ));
            if (k < outLog.size()) check($sformatf("fair_out%0d", k), 32'(outLog[k]), 32'(k % NUM_REQ));
        end
        if (outCyc.size() == 8) check("fair_rate", 32'(outCyc[7] - outCyc[0]), 32'd7);

        randomCycles(300, 100);
        randomCycles(400, 60);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        fails++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $fatal(1, "watchdog expired");
    end

endmodule
